// File: rtl/yuv422_pixel_sequencer.sv
// YUYV 4:2:2 byte stream to per-pixel Y/U/V sequencer with frame sideband.
// Ports: clk/rst (async active-low), enable, in_data/in_valid/in_sof/in_ready
// (byte source), ds_afull (downstream fill), conv_valid/conv_y/conv_u/conv_v
// (converter input), pix_sof/pix_eol/pix_eof (aligned to converter output),
// sync_err (1-cycle pulse on misplaced in_sof).
module yuv422_pixel_sequencer #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int CW     = 10,
    parameter int RW     = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_sof,
    output logic       in_ready,
    input  logic       ds_afull,
    output logic       conv_valid,
    output logic [7:0] conv_y,
    output logic [7:0] conv_u,
    output logic [7:0] conv_v,
    output logic       pix_sof,
    output logic       pix_eol,
    output logic       pix_eof,
    output logic       sync_err
);

    typedef enum logic [2:0] {
        ST_Y0, ST_U, ST_Y1, ST_V, ST_PIX1
    } state_t;

    state_t        state_q;
    logic [7:0]    y0_q, u_q, y1_q, v_q;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic          conv_valid_q, sync_err_q;
    logic [7:0]    conv_y_q, conv_u_q, conv_v_q;
    logic          tag_sof_q, tag_eol_q, tag_eof_q;
    logic          pix_sof_q, pix_eol_q, pix_eof_q;

    logic          accept, at_origin, col_last, row_last;
    logic          issue_v, issue_p, issue, sof_ok, resync;
    logic [CW-1:0] col_nx;
    logic [RW-1:0] row_nx;

    assign in_ready = enable & ~ds_afull;

    always_comb begin
        accept    = in_valid & in_ready;
        at_origin = (col_q == '0) && (row_q == '0);
        col_last  = col_q == CW'(WIDTH - 1);
        row_last  = row_q == RW'(HEIGHT - 1);
        issue_v   = (state_q == ST_V) & accept & ~in_sof;
        issue_p   = state_q == ST_PIX1;
        issue     = issue_v | issue_p;
        col_nx    = col_last ? '0 : col_q + CW'(1);
        row_nx    = row_q;
        if (col_last) begin
            row_nx = row_last ? '0 : row_q + RW'(1);
        end
        // In ST_PIX1 the pending pixel1 still owns col/row, so the new
        // group starts at the position after it; a frame boundary there
        // means pixel1 is the last pixel of the frame.
        sof_ok = ((state_q == ST_Y0) && at_origin) ||
                 ((state_q == ST_PIX1) && col_last && row_last);
        resync = accept & in_sof & ~sof_ok;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_Y0;
            y0_q         <= '0;
            u_q          <= '0;
            y1_q         <= '0;
            v_q          <= '0;
            col_q        <= '0;
            row_q        <= '0;
            conv_valid_q <= 1'b0;
            conv_y_q     <= '0;
            conv_u_q     <= '0;
            conv_v_q     <= '0;
            tag_sof_q    <= 1'b0;
            tag_eol_q    <= 1'b0;
            tag_eof_q    <= 1'b0;
            pix_sof_q    <= 1'b0;
            pix_eol_q    <= 1'b0;
            pix_eof_q    <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            conv_valid_q <= issue;
            sync_err_q   <= resync;
            // Tags ride with conv_valid, then one more stage to match
            // the converter's registered output.
            tag_sof_q    <= issue & at_origin;
            tag_eol_q    <= issue & col_last;
            tag_eof_q    <= issue & col_last & row_last;
            pix_sof_q    <= tag_sof_q;
            pix_eol_q    <= tag_eol_q;
            pix_eof_q    <= tag_eof_q;
            if (issue_v) begin
                conv_y_q <= y0_q;
                conv_u_q <= u_q;
                conv_v_q <= in_data;
            end else if (issue_p) begin
                conv_y_q <= y1_q;
                conv_u_q <= u_q;
                conv_v_q <= v_q;
            end
            if (resync) begin
                col_q <= '0;
                row_q <= '0;
            end else if (issue) begin
                col_q <= col_nx;
                row_q <= row_nx;
            end
            unique case (state_q)
                ST_Y0, ST_PIX1: begin
                    if (accept) begin
                        y0_q    <= in_data;
                        state_q <= ST_U;
                    end else begin
                        state_q <= ST_Y0;
                    end
                end
                ST_U: begin
                    if (resync) begin
                        y0_q <= in_data;
                    end else if (accept) begin
                        u_q     <= in_data;
                        state_q <= ST_Y1;
                    end
                end
                ST_Y1: begin
                    if (resync) begin
                        y0_q    <= in_data;
                        state_q <= ST_U;
                    end else if (accept) begin
                        y1_q    <= in_data;
                        state_q <= ST_V;
                    end
                end
                ST_V: begin
                    if (resync) begin
                        y0_q    <= in_data;
                        state_q <= ST_U;
                    end else if (accept) begin
                        v_q     <= in_data;
                        state_q <= ST_PIX1;
                    end
                end
                default: state_q <= ST_Y0;
            endcase
        end
    end

    assign conv_valid = conv_valid_q;
    assign conv_y     = conv_y_q;
    assign conv_u     = conv_u_q;
    assign conv_v     = conv_v_q;
    assign pix_sof    = pix_sof_q;
    assign pix_eol    = pix_eol_q;
    assign pix_eof    = pix_eof_q;
    assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_yuv422_pixel_sequencer.sv
// Scoreboard bench for yuv422_pixel_sequencer, WIDTH=4 HEIGHT=2.
// Stimulus pushes hand-computed pixels; a negedge monitor pops and compares.
module tb_yuv422_pixel_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_sof = 1'b0;
    logic       in_ready;
    logic       ds_afull = 1'b0;
    logic       conv_valid;
    logic [7:0] conv_y, conv_u, conv_v;
    logic       pix_sof, pix_eol, pix_eof;
    logic       sync_err;

    yuv422_pixel_sequencer #(
        .WIDTH(4), .HEIGHT(2), .CW(2), .RW(1)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
        .in_ready(in_ready), .ds_afull(ds_afull),
        .conv_valid(conv_valid), .conv_y(conv_y),
        .conv_u(conv_u), .conv_v(conv_v),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof),
        .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] y, u, v;
        logic [2:0] tag;
    } px_t;

    px_t  sbq[$];
    logic [2:0] exp_tag = '0;
    int   checks = 0;
    int   errors = 0;
    int   sync_seen = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    task automatic push(input logic [7:0] y, input logic [7:0] u,
                        input logic [7:0] v, input logic [2:0] tag);
        px_t p;
        p.y = y; p.u = u; p.v = v; p.tag = tag;
        sbq.push_back(p);
    endtask

    // tag bits: {sof, eol, eof}
    always @(negedge clk) begin
        if (!rst) begin
            exp_tag = '0;
        end else begin
            chk("pix_tags", {29'd0, pix_sof, pix_eol, pix_eof},
                {29'd0, exp_tag});
            exp_tag = '0;
            if (sync_err) sync_seen++;
            if (conv_valid) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pixel: got %h %h %h expected none",
                             conv_y, conv_u, conv_v);
                end else begin
                    px_t e;
                    e = sbq.pop_front();
                    chk("pixel_yuv", {8'd0, conv_y, conv_u, conv_v},
                        {8'd0, e.y, e.u, e.v});
                    exp_tag = e.tag;
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic s);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = s;
        #0;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got ready=0 expected ready=1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("drain_empty", sbq.size(), 0);
    endtask

    logic [7:0] fb[16];
    int t0, t1;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_conv_valid", conv_valid, 0);
        chk("rst_conv_yuv", {conv_y, conv_u, conv_v}, 0);
        chk("rst_sideband", {pix_sof, pix_eol, pix_eof, sync_err}, 0);
        rst = 1'b1;
        #1;
        chk("rst_ready", in_ready, 1);

        // full frame, continuous
        fb = '{8'h10, 8'h80, 8'h20, 8'h90, 8'h30, 8'h81, 8'h40, 8'h91,
               8'h50, 8'h82, 8'h60, 8'h92, 8'h70, 8'h83, 8'h88, 8'h93};
        push(8'h10, 8'h80, 8'h90, 3'b100);
        push(8'h20, 8'h80, 8'h90, 3'b000);
        push(8'h30, 8'h81, 8'h91, 3'b000);
        push(8'h40, 8'h81, 8'h91, 3'b010);
        push(8'h50, 8'h82, 8'h92, 3'b000);
        push(8'h60, 8'h82, 8'h92, 3'b000);
        push(8'h70, 8'h83, 8'h93, 3'b000);
        push(8'h88, 8'h83, 8'h93, 3'b011);
        t0 = 0;
        for (int i = 0; i < 16; i++) begin
            send(fb[i], i == 0);
            if (i == 0) t0 = cyc;
        end
        t1 = cyc;
        chk("stream_cycles", t1 - t0, 15);
        drain();

        // stall after U, new frame
        push(8'hA0, 8'hB0, 8'hB1, 3'b100);
        push(8'hA1, 8'hB0, 8'hB1, 3'b000);
        send(8'hA0, 1'b1);
        send(8'hB0, 1'b0);
        ds_afull = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hA1;
        #1;
        chk("stall_ready", in_ready, 0);
        repeat (5) @(posedge clk);
        #1;
        ds_afull = 1'b0;
        send(8'hA1, 1'b0);
        send(8'hB1, 1'b0);
        push(8'hC0, 8'hD0, 8'hD1, 3'b000);
        push(8'hC1, 8'hD0, 8'hD1, 3'b010);
        send(8'hC0, 1'b0);
        send(8'hD0, 1'b0);
        send(8'hC1, 1'b0);
        send(8'hD1, 1'b0);
        drain();

        // row 1: two pixels, then in_sof on 3rd byte at col 2
        push(8'hE0, 8'hF0, 8'hF1, 3'b000);
        push(8'hE1, 8'hF0, 8'hF1, 3'b000);
        send(8'hE0, 1'b0);
        send(8'hF0, 1'b0);
        send(8'hE1, 1'b0);
        send(8'hF1, 1'b0);
        drain();
        push(8'h33, 8'h44, 8'h66, 3'b100);
        push(8'h55, 8'h44, 8'h66, 3'b000);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b1);
        send(8'h44, 1'b0);
        send(8'h55, 1'b0);
        send(8'h66, 1'b0);
        drain();
        chk("sync_err_pulses", sync_seen, 1);

        // reset in ST_Y1
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        rst = 1'b0;
        #1;
        chk("midrst_conv", {7'd0, conv_valid, conv_y, conv_u, conv_v},
            32'd0);
        chk("midrst_side", {pix_sof, pix_eol, pix_eof, sync_err}, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        push(8'h05, 8'h06, 8'h08, 3'b100);
        push(8'h07, 8'h06, 8'h08, 3'b000);
        send(8'h05, 1'b0);
        send(8'h06, 1'b0);
        send(8'h07, 1'b0);
        send(8'h08, 1'b0);
        drain();

        // enable low while in ST_PIX1
        push(8'h09, 8'h0A, 8'h0C, 3'b000);
        push(8'h0B, 8'h0A, 8'h0C, 3'b010);
        send(8'h09, 1'b0);
        send(8'h0A, 1'b0);
        send(8'h0B, 1'b0);
        send(8'h0C, 1'b0);
        enable   = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h0D;
        #1;
        chk("disabled_ready", in_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("pix1_while_disabled", sbq.size(), 0);
        enable = 1'b1;
        push(8'h0D, 8'h0E, 8'h1F, 3'b000);
        push(8'h0F, 8'h0E, 8'h1F, 3'b000);
        send(8'h0D, 1'b0);
        send(8'h0E, 1'b0);
        send(8'h0F, 1'b0);
        send(8'h1F, 1'b0);
        drain();
        chk("sync_err_final", sync_seen, 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
